sb_tx_msg_scheduler: RTL and testbench

- Sideband TX front-end controller that shares the sideband header encoder and serializer between two requesters:
  - the LTSM message source;
  - the point/sweep test (PST) engine.
- Arbitrates round-robin between them, drives the encoder with a one-cycle message strobe, and captures the 62-bit header.
- Appends CP/DP parity and emits the header packet, then an optional 64-bit data packet, to the serializer under ready/valid.
- Enforces a minimum idle gap between messages.

---
 rtl/sb_tx_msg_scheduler_if.sv | 72 +++++++
 rtl/sb_tx_msg_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_sb_tx_msg_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_tx_msg_scheduler_if.sv
// Sideband TX scheduler bus bundle.
// Groups every non-clock/reset signal of sb_tx_msg_scheduler:
//   - LTSM requester : req/fields/data in, ack out
//   - PST requester  : req/fields/data in, ack out
//   - header encoder : message strobe and fields out, header/header-valid in
//   - serializer     : packet/valid out, ready in
//   - status         : busy out
// The master modport is the scheduler's view; slave is the environment's view.
interface sb_tx_msg_scheduler_if;
  logic        i_ltsm_req;
  logic [3:0]  i_ltsm_state;
  logic [3:0]  i_ltsm_sub_state;
  logic [3:0]  i_ltsm_msg_no;
  logic [2:0]  i_ltsm_msg_info;
  logic        i_ltsm_data_valid;
  logic [63:0] i_ltsm_data;
  logic        o_ltsm_ack;

  logic        i_pst_req;
  logic [1:0]  i_pst_test;
  logic [3:0]  i_pst_msg_no;
  logic [2:0]  i_pst_msg_info;
  logic        i_pst_data_valid;
  logic [63:0] i_pst_data;
  logic        o_pst_ack;

  logic        o_enc_msg_valid;
  logic        o_enc_data_valid;
  logic [3:0]  o_enc_state;
  logic [3:0]  o_enc_sub_state;
  logic [3:0]  o_enc_msg_no;
  logic [2:0]  o_enc_msg_info;
  logic        o_enc_pst_en;
  logic [1:0]  o_enc_pst_test;
  logic [61:0] i_enc_header;
  logic        i_enc_header_valid;

  logic [63:0] o_pkt;
  logic        o_pkt_valid;
  logic        i_ser_ready;
  logic        o_busy;

  modport master (
    input  i_ltsm_req, i_ltsm_state, i_ltsm_sub_state, i_ltsm_msg_no,
           i_ltsm_msg_info, i_ltsm_data_valid, i_ltsm_data,
    output o_ltsm_ack,
    input  i_pst_req, i_pst_test, i_pst_msg_no, i_pst_msg_info,
           i_pst_data_valid, i_pst_data,
    output o_pst_ack,
    output o_enc_msg_valid, o_enc_data_valid, o_enc_state, o_enc_sub_state,
           o_enc_msg_no, o_enc_msg_info, o_enc_pst_en, o_enc_pst_test,
    input  i_enc_header, i_enc_header_valid,
    output o_pkt, o_pkt_valid,
    input  i_ser_ready,
    output o_busy
  );

  modport slave (
    output i_ltsm_req, i_ltsm_state, i_ltsm_sub_state, i_ltsm_msg_no,
           i_ltsm_msg_info, i_ltsm_data_valid, i_ltsm_data,
    input  o_ltsm_ack,
    output i_pst_req, i_pst_test, i_pst_msg_no, i_pst_msg_info,
           i_pst_data_valid, i_pst_data,
    input  o_pst_ack,
    input  o_enc_msg_valid, o_enc_data_valid, o_enc_state, o_enc_sub_state,
           o_enc_msg_no, o_enc_msg_info, o_enc_pst_en, o_enc_pst_test,
    output i_enc_header, i_enc_header_valid,
    input  o_pkt, o_pkt_valid,
    output i_ser_ready,
    input  o_busy
  );
endinterface

// File: rtl/sb_tx_msg_scheduler.sv
// Sideband TX message scheduler.
// Shares one header encoder and one serializer between the LTSM message source
// and the point/sweep test engine. Requests are arbitrated round-robin, the
// encoder gets a one-cycle strobe, the returned 62-bit header is wrapped with
// CP/DP parity and sent, optionally followed by a 64-bit data packet, and a
// GAP_CYCLES idle gap separates consecutive messages.
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous active-high reset
//   bus    - sb_tx_msg_scheduler_if.master: requesters, encoder, serializer, busy
module sb_tx_msg_scheduler #(
  parameter int GAP_CYCLES = 32
) (
  input logic                   i_clk,
  input logic                   i_rst,
  sb_tx_msg_scheduler_if.master bus
);

  localparam int              CntW    = $clog2(GAP_CYCLES + 1);
  localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES - 1);
  localparam logic [3:0]      MbtrainState = 4'd4;

  typedef enum logic [2:0] {
    IDLE,
    ENCODE,
    WAIT_HDR,
    SEND_HDR,
    SEND_DATA,
    GAP
  } state_t;

  state_t          state_q;
  logic            ptrPst_q;
  logic            ownerPst_q;
  logic [3:0]      encState_q;
  logic [3:0]      encSubState_q;
  logic [3:0]      encMsgNo_q;
  logic [2:0]      encMsgInfo_q;
  logic            encPstEn_q;
  logic [1:0]      encPstTest_q;
  logic            dataValid_q;
  logic [63:0]     data_q;
  logic            encMsgValid_q;
  logic [63:0]     pkt_q;
  logic            pktValid_q;
  logic            ltsmAck_q;
  logic            pstAck_q;
  logic [CntW-1:0] gapCnt_q;

  logic            grantLtsm_d;
  logic            grantPst_d;
  logic [63:0]     hdrPkt_d;
  logic            accept_d;

  // A lone requester always wins; on a tie the round-robin pointer decides.
  // The header packet is assembled straight from the encoder bus so that the
  // packet register doubles as the latched header.
  always_comb begin
    grantLtsm_d = bus.i_ltsm_req && (!bus.i_pst_req || !ptrPst_q);
    grantPst_d  = bus.i_pst_req && (!bus.i_ltsm_req || ptrPst_q);
    hdrPkt_d    = {dataValid_q & (^data_q), ^bus.i_enc_header, bus.i_enc_header};
    accept_d    = pktValid_q & bus.i_ser_ready;
  end

  // Message FSM. All outputs are registered here; strobe and acks default low
  // every cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      ptrPst_q      <= 1'b0;
      ownerPst_q    <= 1'b0;
      encState_q    <= '0;
      encSubState_q <= '0;
      encMsgNo_q    <= '0;
      encMsgInfo_q  <= '0;
      encPstEn_q    <= 1'b0;
      encPstTest_q  <= '0;
      dataValid_q   <= 1'b0;
      data_q        <= '0;
      encMsgValid_q <= 1'b0;
      pkt_q         <= '0;
      pktValid_q    <= 1'b0;
      ltsmAck_q     <= 1'b0;
      pstAck_q      <= 1'b0;
      gapCnt_q      <= '0;
    end else begin
      encMsgValid_q <= 1'b0;
      ltsmAck_q     <= 1'b0;
      pstAck_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grantLtsm_d) begin
            ownerPst_q    <= 1'b0;
            ptrPst_q      <= 1'b1;
            encState_q    <= bus.i_ltsm_state;
            encSubState_q <= bus.i_ltsm_sub_state;
            encMsgNo_q    <= bus.i_ltsm_msg_no;
            encMsgInfo_q  <= bus.i_ltsm_msg_info;
            encPstEn_q    <= 1'b0;
            encPstTest_q  <= '0;
            dataValid_q   <= bus.i_ltsm_data_valid;
            data_q        <= bus.i_ltsm_data;
            encMsgValid_q <= 1'b1;
            state_q       <= ENCODE;
          end else if (grantPst_d) begin
            ownerPst_q    <= 1'b1;
            ptrPst_q      <= 1'b0;
            encState_q    <= MbtrainState;
            encSubState_q <= '0;
            encMsgNo_q    <= bus.i_pst_msg_no;
            encMsgInfo_q  <= bus.i_pst_msg_info;
            encPstEn_q    <= 1'b1;
            encPstTest_q  <= bus.i_pst_test;
            dataValid_q   <= bus.i_pst_data_valid;
            data_q        <= bus.i_pst_data;
            encMsgValid_q <= 1'b1;
            state_q       <= ENCODE;
          end
        end
        ENCODE: begin
          state_q <= WAIT_HDR;
        end
        WAIT_HDR: begin
          if (bus.i_enc_header_valid) begin
            pkt_q      <= hdrPkt_d;
            pktValid_q <= 1'b1;
            state_q    <= SEND_HDR;
          end
        end
        SEND_HDR: begin
          if (accept_d) begin
            if (dataValid_q) begin
              pkt_q   <= data_q;
              state_q <= SEND_DATA;
            end else begin
              pkt_q      <= '0;
              pktValid_q <= 1'b0;
              gapCnt_q   <= GapLoad;
              ltsmAck_q  <= !ownerPst_q;
              pstAck_q   <= ownerPst_q;
              state_q    <= GAP;
            end
          end
        end
        SEND_DATA: begin
          if (accept_d) begin
            pkt_q      <= '0;
            pktValid_q <= 1'b0;
            gapCnt_q   <= GapLoad;
            ltsmAck_q  <= !ownerPst_q;
            pstAck_q   <= ownerPst_q;
            state_q    <= GAP;
          end
        end
        GAP: begin
          if (gapCnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            gapCnt_q <= gapCnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output wiring from the registered state.
  always_comb begin
    bus.o_ltsm_ack       = ltsmAck_q;
    bus.o_pst_ack        = pstAck_q;
    bus.o_enc_msg_valid  = encMsgValid_q;
    bus.o_enc_data_valid = dataValid_q;
    bus.o_enc_state      = encState_q;
    bus.o_enc_sub_state  = encSubState_q;
    bus.o_enc_msg_no     = encMsgNo_q;
    bus.o_enc_msg_info   = encMsgInfo_q;
    bus.o_enc_pst_en     = encPstEn_q;
    bus.o_enc_pst_test   = encPstTest_q;
    bus.o_pkt            = pkt_q;
    bus.o_pkt_valid      = pktValid_q;
    bus.o_busy           = (state_q != IDLE);
  end

endmodule

// File: tb/tb_sb_tx_msg_scheduler.sv
// Self-checking bench for sb_tx_msg_scheduler.
// Requesters, encoder and serializer are modelled at transaction level; the
// expected grant order, encoder fields, packets, acks and gap length come from
// a round-robin pointer and plain parity arithmetic kept in the bench.
module tb_sb_tx_msg_scheduler;

  localparam int GAP = 32;

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  sub;
    logic [3:0]  msgNo;
    logic [2:0]  info;
    logic        dv;
    logic [63:0] data;
    logic [1:0]  test;
  } msg_t;

  logic clk = 1'b0;
  logic rst;

  sb_tx_msg_scheduler_if bus ();

  sb_tx_msg_scheduler #(.GAP_CYCLES(GAP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          passCount = 0;
  int          checkCount = 0;
  int          cycle = 0;
  int          lastAck = -1;
  logic        ptrPst = 1'b0;
  logic        ltsmReq = 1'b0;
  logic        pstReq = 1'b0;
  msg_t        ltsmMsg = '0;
  msg_t        pstMsg = '0;
  logic        hdrValid = 1'b0;
  logic [61:0] hdr = '0;
  logic        serReady = 1'b0;
  logic [63:0] firstPkt;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // Copies the bench-side requester/encoder/serializer state onto the bus.
  task automatic applyStimulus();
    bus.i_ltsm_req         = ltsmReq;
    bus.i_ltsm_state       = ltsmMsg.st;
    bus.i_ltsm_sub_state   = ltsmMsg.sub;
    bus.i_ltsm_msg_no      = ltsmMsg.msgNo;
    bus.i_ltsm_msg_info    = ltsmMsg.info;
    bus.i_ltsm_data_valid  = ltsmMsg.dv;
    bus.i_ltsm_data        = ltsmMsg.data;
    bus.i_pst_req          = pstReq;
    bus.i_pst_test         = pstMsg.test;
    bus.i_pst_msg_no       = pstMsg.msgNo;
    bus.i_pst_msg_info     = pstMsg.info;
    bus.i_pst_data_valid   = pstMsg.dv;
    bus.i_pst_data         = pstMsg.data;
    bus.i_enc_header       = hdr;
    bus.i_enc_header_valid = hdrValid;
    bus.i_ser_ready        = serReady;
  endtask

  task automatic tick();
    @(negedge clk);
    cycle++;
  endtask

  function automatic msg_t randMsg();
    msg_t m;
    m.st    = 4'($urandom);
    m.sub   = 4'($urandom);
    m.msgNo = 4'($urandom);
    m.info  = 3'($urandom);
    m.dv    = 1'($urandom);
    m.data  = {$urandom, $urandom};
    m.test  = 2'($urandom);
    return m;
  endfunction

  // Raises requesters that are currently idle; pending ones keep their fields.
  task automatic nextReqs(input bit rl, input bit rp);
    if (rl && !ltsmReq) begin ltsmMsg = randMsg(); ltsmReq = 1'b1; end
    if (rp && !pstReq) begin pstMsg = randMsg(); pstReq = 1'b1; end
    applyStimulus();
  endtask

  // Counts GAP cycles starting at the ack cycle until busy drops.
  task automatic waitGap();
    int n = 0;
    while (bus.o_busy && n < 200) begin
      n++;
      tick();
      if (n == 1) checkOutput("ackSinglePulse", 64'({bus.o_ltsm_ack, bus.o_pst_ack}), 64'd0);
    end
    checkOutput("gapLength", 64'(n), 64'(GAP));
    if (!ltsmReq && !pstReq) lastAck = -1;
  endtask

  // One complete message from the current pending requests, entered on an
  // IDLE (or post-reset) negedge and left on the ack negedge.
  task automatic doMessage(input int hdrDelay, input int hdrStall, input int stallPct,
                           input bit resetInData, input bit useHdr,
                           input logic [61:0] hdrIn, output logic [63:0] pktOut);
    bit          winPst;
    msg_t        m;
    int          waitN;
    int          idx;
    int          nPkt;
    int          stalled;
    logic [63:0] expPkt [2];
    pktOut = '0;
    winPst = pstReq && (!ltsmReq || ptrPst);
    ptrPst = !winPst;
    m      = winPst ? pstMsg : ltsmMsg;

    waitN = 0;
    while (!bus.o_enc_msg_valid && waitN < 200) begin
      tick();
      waitN++;
    end
    checkOutput("strobeSeen", 64'(bus.o_enc_msg_valid), 64'd1);
    if (!bus.o_enc_msg_valid) return;
    if (lastAck >= 0) checkOutput("grantSpacing", 64'(cycle - lastAck), 64'(GAP + 1));
    checkOutput("encPstEn", 64'(bus.o_enc_pst_en), 64'(winPst));
    checkOutput("encState", 64'(bus.o_enc_state), 64'(winPst ? 4'd4 : m.st));
    checkOutput("encSubState", 64'(bus.o_enc_sub_state), 64'(winPst ? 4'd0 : m.sub));
    checkOutput("encMsgNo", 64'(bus.o_enc_msg_no), 64'(m.msgNo));
    checkOutput("encMsgInfo", 64'(bus.o_enc_msg_info), 64'(m.info));
    checkOutput("encDataValid", 64'(bus.o_enc_data_valid), 64'(m.dv));
    checkOutput("encPstTest", 64'(bus.o_enc_pst_test), 64'(winPst ? m.test : 2'd0));
    checkOutput("busyInMsg", 64'(bus.o_busy), 64'd1);

    tick();
    checkOutput("strobeOneCycle", 64'(bus.o_enc_msg_valid), 64'd0);
    for (int i = 0; i < hdrDelay; i++) begin
      tick();
      checkOutput("noPktBeforeHdr", 64'(bus.o_pkt_valid), 64'd0);
      checkOutput("noSecondStrobe", 64'(bus.o_enc_msg_valid), 64'd0);
    end
    hdr      = useHdr ? hdrIn : 62'({$urandom, $urandom});
    hdrValid = 1'b1;
    applyStimulus();
    expPkt[0] = {m.dv ? ^m.data : 1'b0, ^hdr, hdr};
    expPkt[1] = m.data;
    nPkt      = m.dv ? 2 : 1;
    tick();
    hdrValid = 1'b0;
    applyStimulus();

    idx     = 0;
    waitN   = 0;
    stalled = 0;
    while (idx < nPkt && waitN < 300) begin
      checkOutput("pktValid", 64'(bus.o_pkt_valid), 64'd1);
      checkOutput(idx == 0 ? "hdrPkt" : "dataPkt", bus.o_pkt, expPkt[idx]);
      checkOutput("noEarlyAck", 64'({bus.o_ltsm_ack, bus.o_pst_ack}), 64'd0);
      if (idx == 0 && stalled == 0) pktOut = bus.o_pkt;
      if (resetInData && idx == 1) begin
        rst = 1'b1;
        #1;
        checkOutput("rstPkt", bus.o_pkt, 64'd0);
        checkOutput("rstPktValid", 64'(bus.o_pkt_valid), 64'd0);
        checkOutput("rstBusy", 64'(bus.o_busy), 64'd0);
        checkOutput("rstEncState", 64'(bus.o_enc_state), 64'd0);
        checkOutput("rstEncPstEn", 64'(bus.o_enc_pst_en), 64'd0);
        ptrPst  = 1'b0;
        lastAck = -1;
        tick();
        checkOutput("rstNoAck", 64'({bus.o_ltsm_ack, bus.o_pst_ack}), 64'd0);
        rst = 1'b0;
        applyStimulus();
        return;
      end
      if (idx == 0 && stalled < hdrStall) begin
        serReady = 1'b0;
        stalled++;
      end else begin
        serReady = ($urandom_range(99) >= stallPct);
      end
      applyStimulus();
      if (serReady) idx++;
      tick();
      waitN++;
    end
    checkOutput("pktPhaseDone", 64'(idx >= nPkt), 64'd1);
    serReady = 1'b0;
    applyStimulus();

    checkOutput("ltsmAck", 64'(bus.o_ltsm_ack), 64'(!winPst));
    checkOutput("pstAck", 64'(bus.o_pst_ack), 64'(winPst));
    checkOutput("pktIdleAfter", 64'(bus.o_pkt_valid), 64'd0);
    lastAck = cycle;
    if (winPst) pstReq = 1'b0;
    else ltsmReq = 1'b0;
    applyStimulus();
  endtask

  // Watchdog so a stuck DUT still produces a verdict.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit rl;
    bit rp;
    rst = 1'b1;
    applyStimulus();
    repeat (2) tick();
    checkOutput("resetBusy", 64'(bus.o_busy), 64'd0);
    checkOutput("resetPktValid", 64'(bus.o_pkt_valid), 64'd0);
    checkOutput("resetPkt", bus.o_pkt, 64'd0);
    checkOutput("resetStrobe", 64'(bus.o_enc_msg_valid), 64'd0);
    checkOutput("resetAcks", 64'({bus.o_ltsm_ack, bus.o_pst_ack}), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("idleNoReq", 64'(bus.o_busy), 64'd0);

    // Reset during the data packet: LTSM in flight, PST also waiting.
    ltsmMsg    = randMsg();
    ltsmMsg.dv = 1'b1;
    pstMsg       = randMsg();
    pstMsg.test  = 2'd2;
    pstMsg.dv    = 1'b1;
    pstMsg.data  = 64'h3;
    ltsmReq = 1'b1;
    pstReq  = 1'b1;
    applyStimulus();
    doMessage(0, 0, 0, 1'b1, 1'b0, '0, firstPkt);
    // After reset the pointer favours LTSM again.
    doMessage(0, 0, 0, 1'b0, 1'b0, '0, firstPkt);
    waitGap();

    // PST message with data, header 3: both parities zero.
    doMessage(0, 0, 20, 1'b0, 1'b1, 62'h3, firstPkt);
    checkOutput("pstVecHdrPkt", firstPkt, 64'h3);
    ltsmMsg       = '0;
    ltsmMsg.st    = 4'd2;
    ltsmMsg.msgNo = 4'd1;
    ltsmReq       = 1'b1;
    applyStimulus();
    waitGap();

    // LTSM only, header 1: CP set.
    doMessage(0, 0, 0, 1'b0, 1'b1, 62'h1, firstPkt);
    checkOutput("ltsmVecHdrPkt", firstPkt, 64'h4000_0000_0000_0001);
    nextReqs(1'b1, 1'b0);
    waitGap();

    // Serializer holds ready low for 5 cycles on the header.
    doMessage(0, 5, 0, 1'b0, 1'b0, '0, firstPkt);
    nextReqs(1'b0, 1'b1);
    waitGap();

    // Encoder withholds the header for 10 cycles.
    doMessage(10, 0, 0, 1'b0, 1'b0, '0, firstPkt);

    // Both requesters continuously busy, then fully random traffic.
    for (int i = 0; i < 20; i++) begin
      if (i < 4) begin
        rl = 1'b1;
        rp = 1'b1;
      end else begin
        rl = 1'($urandom);
        rp = 1'($urandom);
        if (!rl && !rp && !ltsmReq && !pstReq) rl = 1'b1;
      end
      nextReqs(rl, rp);
      waitGap();
      doMessage($urandom_range(3), $urandom_range(2), 30, 1'b0, 1'b0, '0, firstPkt);
    end
    waitGap();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
